// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline control definitions: controller states and pipeline constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MDU_WAIT = 2'd2
    } ctrl_state_t;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard sources in, pipeline stall/flush controls out.
// Latency: n/a (wires only); outputs are combinational in the controller.
// Backpressure: n/a; this bundle carries the stall signals themselves.
//
// master: pipeline side (drives hazard sources, consumes controls)
// slave : hazard_ctrl
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
) ();
    // hazard sources from ID / EX
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_redirect;
    logic             ex_mdu_start;
    logic             mdu_done;
    // pipeline controls
    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_hold;
    logic             ex_mem_bubble;
    logic             mdu_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, ex_mdu_start, mdu_done,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_hold,
               ex_mem_bubble, mdu_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, ex_mdu_start, mdu_done,
        output pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_hold,
               ex_mem_bubble, mdu_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_detect.sv
// Load-use hazard compare between the load in EX and the source regs of the ID instruction.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result feeds the stall sequencer.
//
// Ports: id_rs1_i/id_rs2_i/id_use_rs1_i/id_use_rs2_i (ID sources), ex_rd_i/ex_mem_read_i
//        (EX load), load_use_o (hazard present this cycle).
module hazard_ctrl_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_mem_read_i,
    output logic       load_use_o
);
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);

    // x0 is hardwired, so a load targeting it never produces a dependency
    assign load_use_o = ex_mem_read_i && (ex_rd_i != REG_ZERO) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use bubbles, redirect flushes, MDU holds.
// Latency: controls are combinational from registered state + current inputs (same cycle).
// Backpressure: it is the pipeline's stall source; it accepts no backpressure itself.
//
// Ports: clk, reset (sync, active-high), hz (slave modport: hazard sources in, controls and
//        saturating stall/flush counters out).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,    // 1..7
    parameter int MDU_TIMEOUT  = 64,   // 0 disables the timeout
    parameter int CNT_W        = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);
    localparam logic [1:0] S_RUN   = 2'(RUN);
    localparam logic [1:0] S_FLUSH = 2'(FLUSH);
    localparam logic [1:0] S_WAIT  = 2'(MDU_WAIT);

    localparam int         TW      = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO  = TW'(MDU_TIMEOUT);
    localparam logic [2:0] FC_INIT = 3'(FLUSH_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [TW-1:0]    tcnt_inc;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic mdu_stall;     // MDU hold: PC, IF_ID, EX held; EX_MEM gets bubbles
    logic flush;         // redirect flush of IF_ID and ID_EX
    logic lu_stall;      // single-cycle load-use bubble
    logic redirect_acc;
    logic pc_stall;

    hazard_ctrl_detect u_detect (
        .id_rs1_i      (hz.id_rs1),
        .id_rs2_i      (hz.id_rs2),
        .id_use_rs1_i  (hz.id_use_rs1),
        .id_use_rs2_i  (hz.id_use_rs2),
        .ex_rd_i       (hz.ex_rd),
        .ex_mem_read_i (hz.ex_mem_read),
        .load_use_o    (load_use)
    );

    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        tcnt_d       = tcnt_q;
        err_d        = err_q;
        tcnt_inc     = tcnt_q + TW'(1);
        mdu_stall    = 1'b0;
        flush        = 1'b0;
        lu_stall     = 1'b0;
        redirect_acc = 1'b0;

        case (state_q)
            S_RUN: begin
                // redirect and MDU are both EX ops; redirect kills the MDU op behind it
                if (hz.ex_redirect) begin
                    flush        = 1'b1;
                    redirect_acc = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = S_FLUSH;
                        fcnt_d  = FC_INIT;
                    end
                end else if (hz.ex_mdu_start) begin
                    // a single-cycle MDU result needs no hold at all
                    if (!hz.mdu_done) begin
                        mdu_stall = 1'b1;
                        state_d   = S_WAIT;
                        tcnt_d    = '0;
                    end
                end else if (load_use) begin
                    // the inserted bubble removes the load from EX, so no state is kept
                    lu_stall = 1'b1;
                end
            end

            S_FLUSH: begin
                flush  = 1'b1;
                fcnt_d = fcnt_q - 3'd1;
                if (fcnt_q == 3'd1) begin
                    state_d = S_RUN;
                end
            end

            S_WAIT: begin
                tcnt_d = tcnt_inc;
                if (hz.mdu_done) begin
                    state_d = S_RUN;
                end else if ((MDU_TIMEOUT != 0) && (tcnt_inc == TMO)) begin
                    // give up on the MDU: release the pipe in this cycle, as a done would
                    state_d = S_RUN;
                    err_d   = 1'b1;
                end else begin
                    mdu_stall = 1'b1;
                end
            end

            default: begin
                state_d = S_RUN;
            end
        endcase

        pc_stall = mdu_stall | lu_stall;

        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        flush_cnt_d = flush_cnt_q;
        if (redirect_acc && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RUN;
            fcnt_q      <= '0;
            tcnt_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            tcnt_q      <= tcnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.pc_stall      = pc_stall;
    assign hz.if_id_stall   = pc_stall;
    assign hz.if_id_flush   = flush;
    assign hz.id_ex_flush   = flush | lu_stall;
    assign hz.ex_hold       = mdu_stall;
    assign hz.ex_mem_bubble = mdu_stall;
    assign hz.mdu_err       = err_q;
    assign hz.stall_cnt     = stall_cnt_q;
    assign hz.flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two configurations driven by the same stimulus, scoreboard checked.
// Latency: expectations are for the same cycle the stimulus is applied.
// Backpressure: n/a.
module tb_hazard_ctrl;
    localparam int A_FC = 2, A_TMO = 8, A_CW = 32;
    localparam int B_FC = 3, B_TMO = 0, B_CW = 4;

    typedef struct {
        bit       reset;
        bit [4:0] rs1, rs2, rd;
        bit       use1, use2, mem_read, redirect, start, done;
    } stim_t;

    // flags: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_hold, ex_mem_bubble, mdu_err}
    typedef struct {
        logic [6:0]  flags;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    // reference state: how many flush cycles remain, and how long an MDU op has been waiting
    typedef struct {
        int     flush_left;
        bit     in_wait;
        int     age;
        bit     err;
        longint sc;
        longint fcn;
    } mst_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    mst_t ma, mb;

    hazard_ctrl_if #(.CNT_W(A_CW)) ifa ();
    hazard_ctrl_if #(.CNT_W(B_CW)) ifb ();

    hazard_ctrl #(.FLUSH_CYCLES(A_FC), .MDU_TIMEOUT(A_TMO), .CNT_W(A_CW)) dut_a (
        .clk   (clk),
        .reset (rst),
        .hz    (ifa)
    );

    hazard_ctrl #(.FLUSH_CYCLES(B_FC), .MDU_TIMEOUT(B_TMO), .CNT_W(B_CW)) dut_b (
        .clk   (clk),
        .reset (rst),
        .hz    (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step(input mst_t s, input stim_t in, input int fcyc, input int tmo,
                              input int cw, output mst_t n, output exp_t e);
        longint mx;
        bit lu, stall, fl, lus, pc;
        mx    = (longint'(1) << cw) - 1;
        lu    = in.mem_read && (in.rd != 0) &&
                ((in.use1 && in.rs1 == in.rd) || (in.use2 && in.rs2 == in.rd));
        stall = 0;
        fl    = 0;
        lus   = 0;
        n     = s;
        if (s.flush_left > 0) begin
            fl           = 1;
            n.flush_left = s.flush_left - 1;
        end else if (s.in_wait) begin
            n.age = s.age + 1;
            if (in.done) begin
                n.in_wait = 0;
            end else if (tmo != 0 && n.age == tmo) begin
                n.in_wait = 0;
                n.err     = 1;
            end else begin
                stall = 1;
            end
        end else if (in.redirect) begin
            fl           = 1;
            n.fcn        = (s.fcn < mx) ? s.fcn + 1 : s.fcn;
            n.flush_left = fcyc - 1;
        end else if (in.start) begin
            if (!in.done) begin
                stall     = 1;
                n.in_wait = 1;
                n.age     = 0;
            end
        end else if (lu) begin
            lus = 1;
        end
        pc = stall | lus;
        if (pc && s.sc < mx) n.sc = s.sc + 1;
        e.flags = {pc, pc, fl, fl | lus, stall, stall, s.err};
        e.sc    = 32'(s.sc);
        e.fc    = 32'(s.fcn);
        if (in.reset) n = '{default: 0};
    endtask

    task automatic drive_if(input stim_t s);
        ifa.id_rs1 = s.rs1;  ifa.id_rs2 = s.rs2;  ifa.ex_rd = s.rd;
        ifa.id_use_rs1 = s.use1;  ifa.id_use_rs2 = s.use2;  ifa.ex_mem_read = s.mem_read;
        ifa.ex_redirect = s.redirect;  ifa.ex_mdu_start = s.start;  ifa.mdu_done = s.done;
        ifb.id_rs1 = s.rs1;  ifb.id_rs2 = s.rs2;  ifb.ex_rd = s.rd;
        ifb.id_use_rs1 = s.use1;  ifb.id_use_rs2 = s.use2;  ifb.ex_mem_read = s.mem_read;
        ifb.ex_redirect = s.redirect;  ifb.ex_mdu_start = s.start;  ifb.mdu_done = s.done;
    endtask

    // one clock of stimulus; expectations are queued for the monitor
    task automatic cyc(input stim_t s);
        exp_t e;
        mst_t n;
        @(posedge clk);
        #1;
        rst = s.reset;
        drive_if(s);
        model_step(ma, s, A_FC, A_TMO, A_CW, n, e);
        qa.push_back(e);
        ma = n;
        model_step(mb, s, B_FC, B_TMO, B_CW, n, e);
        qb.push_back(e);
        mb = n;
    endtask

    task automatic idle(input int n);
        stim_t s;
        s = '{default: 0};
        for (int i = 0; i < n; i++) cyc(s);
    endtask

    task automatic check(input string tag, input exp_t e, input logic [6:0] f,
                         input logic [31:0] sc, input logic [31:0] fc);
        checks++;
        if (f !== e.flags) begin
            errors++;
            $display("FAIL %s flags: got %b want %b at %0t", tag, f, e.flags, $time);
        end
        checks++;
        if (sc !== e.sc) begin
            errors++;
            $display("FAIL %s stall_cnt: got %0d want %0d at %0t", tag, sc, e.sc, $time);
        end
        checks++;
        if (fc !== e.fc) begin
            errors++;
            $display("FAIL %s flush_cnt: got %0d want %0d at %0t", tag, fc, e.fc, $time);
        end
    endtask

    // monitor: controls are valid every cycle, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check("A", e, {ifa.pc_stall, ifa.if_id_stall, ifa.if_id_flush, ifa.id_ex_flush,
                           ifa.ex_hold, ifa.ex_mem_bubble, ifa.mdu_err},
                  ifa.stall_cnt, ifa.flush_cnt);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check("B", e, {ifb.pc_stall, ifb.if_id_stall, ifb.if_id_flush, ifb.id_ex_flush,
                           ifb.ex_hold, ifb.ex_mem_bubble, ifb.mdu_err},
                  32'(ifb.stall_cnt), 32'(ifb.flush_cnt));
        end
    end

    initial begin
        stim_t s;
        int    guard;
        rst = 1'b1;
        s   = '{default: 0};
        drive_if(s);
        ma  = '{default: 0};   // first edge sees reset asserted
        mb  = '{default: 0};

        // reset held for three edges, then quiet
        s.reset = 1;
        cyc(s);
        cyc(s);
        idle(2);

        // load-use on rs2, then the same with x0 as destination
        s = '{default: 0};
        s.mem_read = 1; s.rd = 5; s.rs2 = 5; s.use2 = 1;
        cyc(s);
        idle(2);
        s.rd = 0; s.rs2 = 0; s.rs1 = 0; s.use1 = 1;
        cyc(s);
        idle(2);

        // redirect followed by a redirect while flushing
        s = '{default: 0};
        s.redirect = 1;
        cyc(s);
        cyc(s);
        idle(5);

        // MDU op finishing after 10 cycles
        s = '{default: 0};
        s.start = 1;
        cyc(s);
        idle(9);
        s = '{default: 0};
        s.done = 1;
        cyc(s);
        idle(3);

        // MDU op that never finishes (times out only where enabled)
        s = '{default: 0};
        s.start = 1;
        cyc(s);
        idle(14);
        s = '{default: 0};
        s.done = 1;
        cyc(s);
        idle(4);

        // redirect, MDU start and load-use together; then reset during an MDU hold
        s = '{default: 0};
        s.redirect = 1; s.start = 1; s.mem_read = 1; s.rd = 7; s.rs1 = 7; s.use1 = 1;
        cyc(s);
        idle(4);
        s = '{default: 0};
        s.start = 1;
        cyc(s);
        idle(3);
        s = '{default: 0};
        s.reset = 1;
        cyc(s);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s.reset    = ($urandom_range(0, 79) == 0);
            s.rd       = 5'($urandom_range(0, 3));
            s.rs1      = 5'($urandom_range(0, 3));
            s.rs2      = 5'($urandom_range(0, 3));
            s.use1     = 1'($urandom_range(0, 1));
            s.use2     = 1'($urandom_range(0, 1));
            s.mem_read = ($urandom_range(0, 2) == 0);
            s.redirect = ($urandom_range(0, 9) == 0);
            s.start    = ($urandom_range(0, 7) == 0);
            s.done     = ($urandom_range(0, 5) == 0);
            cyc(s);
        end
        idle(2);

        guard = 0;
        while ((qa.size() > 0 || qb.size() > 0) && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (qa.size() > 0 || qb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d/%0d expectations left, want 0", qa.size(), qb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
